uart_tx: RTL and testbench

Standalone 8N1/8N2 UART transmitter. It serialises bytes presented on a valid/ready byte interface onto the board TX line. It is the transmit-side counterpart used wherever the design must originate serial traffic rather than echo it. It sits between a byte producer (message sender, register dump logic) and the top-level tx pin, with the baud timing derived internally from the system clock.

---
 rtl/uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Standalone 8N1 / 8N2 UART transmitter. Bytes offered on a valid/ready
// interface are serialised LSB first onto the tx line: one start bit (low),
// eight data bits, then STOP_BITS stop bits (high). The bit period is derived
// from the system clock as CLKS_PER_BIT = CLK_HZ / BAUD (truncating).
//
// Handshake: a byte is transferred on every rising edge where
// tx_valid && tx_ready. tx_ready is high only while the transmitter is idle.
// The producer may change tx_data freely after the transfer, and tx_valid
// raised while a frame is in flight is ignored (nothing is queued).
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous, active-high reset
//   tx_valid   producer has a byte on tx_data
//   tx_data    byte to send, LSB transmitted first
//   tx_ready   high only in IDLE
//   tx         serial line, idle high, driven straight from a flop
//   busy       high from the cycle after accept until the FSM is back in IDLE
//   tx_done    one-cycle pulse on the first IDLE cycle after a frame
//   dbg_state  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_HZ    = 25_000_000,
    parameter int BAUD      = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] dbg_state
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    // Keep the counter at least one bit wide so an illegal setting still
    // elaborates far enough to reach the fatal check below.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $fatal(1, "uart_tx: CLK_HZ / BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;      // clock count inside the current bit
    logic [2:0]       r_bit_idx;  // data bit 0..7, reused as stop-bit index
    logic [7:0]       r_shift;    // captured byte, shifted right per data bit
    logic             r_tx;
    logic             r_done;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_bit_next;
    logic [7:0]       w_shift_next;
    logic             w_tx_next;
    logic             w_done_next;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_done_next  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_shift_next = tx_data;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_next   = '0;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next   = r_bit_idx + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == STOP_LAST) begin
                        w_bit_next   = '0;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_cnt_next   = '0;
                w_bit_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The line level is decoded from the *next* state so the registered tx
    // changes on the same edge the FSM enters a new bit; this puts the start
    // bit on the line in the cycle right after accept.
    always_comb begin
        w_tx_next = 1'b1;
        unique case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx        = r_tx;
    assign tx_done   = r_done;
    assign tx_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Bench for uart_tx at CLK_HZ=16, BAUD=1 (16 clocks per bit). Two instances
// share clock and reset: u_dut_a with one stop bit, u_dut_b with two.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CLK_HZ     = 16;
    localparam int BAUD       = 1;
    localparam int CPB        = CLK_HZ / BAUD;
    localparam int WAIT_LIMIT = 400;
    localparam int NV         = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (STOP_BITS=1) ----------------
    logic       a_valid = 1'b0;
    logic [7:0] a_data  = 8'h00;
    logic       a_ready, a_tx, a_busy, a_done;
    logic [1:0] a_state;

    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STOP_BITS(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (a_valid),
        .tx_data   (a_data),
        .tx_ready  (a_ready),
        .tx        (a_tx),
        .busy      (a_busy),
        .tx_done   (a_done),
        .dbg_state (a_state)
    );

    // ---------------- DUT B (STOP_BITS=2) ----------------
    logic       b_valid = 1'b0;
    logic [7:0] b_data  = 8'h00;
    logic       b_ready, b_tx, b_busy, b_done;
    logic [1:0] b_state;

    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STOP_BITS(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (b_valid),
        .tx_data   (b_data),
        .tx_ready  (b_ready),
        .tx        (b_tx),
        .busy      (b_busy),
        .tx_done   (b_done),
        .dbg_state (b_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- DUT selection helpers ----------------
    // Returns {ready, done, busy, tx} of the instance with the given stop bits.
    function automatic logic [3:0] sample(input int sb);
        if (sb == 2) return {b_ready, b_done, b_busy, b_tx};
        return {a_ready, a_done, a_busy, a_tx};
    endfunction

    task automatic drive(input int sb, input logic v, input logic [7:0] d);
        if (sb == 2) begin
            b_valid = v;
            b_data  = d;
        end else begin
            a_valid = v;
            a_data  = d;
        end
    endtask

    // ---------------- reference model ----------------
    // Line bits in transmit order: start 0, data LSB first, sb stop 1s.
    function automatic logic [11:0] build_frame(input logic [7:0] d, input int sb);
        bit          q[$];
        logic [11:0] f;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        for (int s = 0; s < sb; s++) q.push_back(1'b1);
        f = '0;
        for (int i = 0; i < q.size(); i++) f[i] = q[i];
        return f;
    endfunction

    // Offers byte d, then checks every cycle from T+1 to the tx_done cycle
    // against the expected frame, and decodes the line at mid-bit like a
    // receiver. Returns at the falling edge of the tx_done cycle.
    task automatic send_frame(input string tag, input logic [7:0] d, input int sb,
                              input logic [11:0] frame, input bit hold,
                              input int disturb_at, input int exp_wait);
        int          n;
        int          nbits;
        int          total;
        int          idx;
        int          err_tx, err_busy, err_done, err_ready, err_frame;
        logic [3:0]  s;
        logic [11:0] rx;
        logic        e_tx, e_busy, e_done, e_ready;

        n = 0;
        s = sample(sb);
        while (!s[3] && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
            s = sample(sb);
        end
        if (s[3] !== 1'b1) begin
            check({tag, "_ready_timeout"}, 32'(s[3]), 32'd1);
            return;
        end
        if (exp_wait >= 0) check({tag, "_accept_wait"}, n, exp_wait);

        drive(sb, 1'b1, d);
        @(posedge clk);

        nbits     = 9 + sb;
        total     = nbits * CPB;
        err_tx    = 0;
        err_busy  = 0;
        err_done  = 0;
        err_ready = 0;
        rx        = '0;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            s = sample(sb);
            if (k <= total) begin
                idx     = (k - 1) / CPB;
                e_tx    = frame[idx];
                e_busy  = 1'b1;
                e_done  = 1'b0;
                e_ready = 1'b0;
                if ((k - 1) % CPB == CPB / 2) rx[idx] = s[0];
            end else begin
                e_tx    = 1'b1;
                e_busy  = 1'b0;
                e_done  = 1'b1;
                e_ready = 1'b1;
            end
            if (s[0] !== e_tx)    err_tx++;
            if (s[1] !== e_busy)  err_busy++;
            if (s[2] !== e_done)  err_done++;
            if (s[3] !== e_ready) err_ready++;
            if (k == 1 && !hold)       drive(sb, 1'b0, d);
            if (k == disturb_at)       drive(sb, 1'b1, 8'hFF);
            if (k == disturb_at + 1)   drive(sb, 1'b0, 8'hFF);
        end

        err_frame = 0;
        if (rx[0] !== 1'b0) err_frame++;
        for (int j = 9; j < nbits; j++) if (rx[j] !== 1'b1) err_frame++;

        check({tag, "_tx_bad_cycles"},    err_tx,    0);
        check({tag, "_busy_bad_cycles"},  err_busy,  0);
        check({tag, "_done_bad_cycles"},  err_done,  0);
        check({tag, "_ready_bad_cycles"}, err_ready, 0);
        check({tag, "_rx_byte"},          32'(rx[8:1]), 32'(d));
        check({tag, "_rx_framing_errs"},  err_frame, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  data;
        int          sb;
        logic [11:0] frame;   // expected line bits, bit 0 sent first
    } vec_t;

    vec_t vecs[NV];

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int         quiet_bad;
        int         d;
        int         sb;
        int         gap;

        vecs[0] = '{8'h55, 1, 12'h2AA};
        vecs[1] = '{8'hA5, 1, 12'h34A};
        vecs[2] = '{8'h3C, 1, 12'h278};
        vecs[3] = '{8'hFF, 1, 12'h3FE};
        vecs[4] = '{8'hC3, 2, 12'h786};
        vecs[5] = '{8'h00, 2, 12'h600};

        // Asynchronous reset, asserted before any clock edge.
        #3 rst = 1'b1;
        #1;
        check("rst_a_tx",    32'(a_tx),    32'd1);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_a_busy",  32'(a_busy),  32'd0);
        check("rst_a_done",  32'(a_done),  32'd0);
        check("rst_a_state", 32'(a_state), 32'd0);
        check("rst_b_tx",    32'(b_tx),    32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_b_state", 32'(b_state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single frames (includes 0x55 and the 2-stop 0xC3).
        for (int i = 0; i < NV; i++) begin
            send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].sb,
                       vecs[i].frame, 1'b0, -5, -1);
            drive(vecs[i].sb, 1'b0, 8'h00);
            repeat (2) @(negedge clk);
        end

        // Back-to-back with tx_valid held: second accept on the tx_done cycle.
        send_frame("b2b_a5", 8'hA5, 1, 12'h34A, 1'b1, -5, -1);
        send_frame("b2b_3c", 8'h3C, 1, 12'h278, 1'b0, -5, 0);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // tx_valid pulsed and tx_data changed to 0xFF mid-frame: ignored.
        send_frame("ign_81", 8'h81, 1, 12'h302, 1'b0, 40, -1);
        quiet_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || a_busy !== 1'b0) quiet_bad++;
        end
        check("ign_no_second_frame", quiet_bad, 0);

        // Reset at T+60 (data bit 2 of 0x5A, a low bit).
        drive(1, 1'b1, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 8'h5A);
        repeat (59) @(negedge clk);
        check("abort_pre_tx",   32'(a_tx),   32'd0);
        check("abort_pre_busy", 32'(a_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_tx",    32'(a_tx),    32'd1);
        check("abort_ready", 32'(a_ready), 32'd1);
        check("abort_busy",  32'(a_busy),  32'd0);
        check("abort_done",  32'(a_done),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet_bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (a_done !== 1'b0 || a_tx !== 1'b1) quiet_bad++;
        end
        check("abort_no_done", quiet_bad, 0);
        send_frame("post_rst_00", 8'h00, 1, 12'h200, 1'b0, -5, 0);
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        send_frame("post_rst_ff", 8'hFF, 1, 12'h3FE, 1'b0, -5, 0);
        drive(1, 1'b0, 8'h00);

        // Randomised frames against the model.
        for (int r = 0; r < 12; r++) begin
            d   = $urandom_range(0, 255);
            sb  = $urandom_range(1, 2);
            gap = $urandom_range(0, 5);
            repeat (gap) @(negedge clk);
            send_frame($sformatf("rnd%0d", r), 8'(d), sb, build_frame(8'(d), sb),
                       1'b0, -5, -1);
            drive(sb, 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
